// File: rtl/multdiv_sequencer.sv
// Request/response sequencer in front of the shared iterative multdiv unit.
// It issues one start pulse per legal request and returns the result, exception or timeout status.
module multdiv_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mult,
    input  logic             req_div,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] md_operandA,
    output logic [WIDTH-1:0] md_operandB,
    output logic             md_ctrl_mult,
    output logic             md_ctrl_div,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_exception,
    output logic             resp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             mult_q, mult_d;
    logic             exc_q, exc_d;
    logic             tmo_q, tmo_d;
    logic             cnt_last;

    // The unit gets TIMEOUT full WAIT cycles (counter 0 .. TIMEOUT-1) to answer.
    assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        tag_d   = tag_q;
        mult_d  = mult_q;
        exc_d   = exc_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    a_d    = req_a;
                    b_d    = req_b;
                    tag_d  = req_tag;
                    mult_d = req_mult;
                    if (req_mult ^ req_div) begin
                        state_d = S_START;
                    end else begin
                        res_d   = '0;
                        exc_d   = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_START: begin
                // md_ready here may be left over from a previous operation.
                cnt_d   = '0;
                state_d = flush ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = S_ABORT;
                end else if (md_ready) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    tmo_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_last) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_ABORT: begin
                // The unit cannot be cancelled; drain it before taking new work.
                cnt_d = cnt_q + CNT_W'(1);
                if (md_ready || cnt_last) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            mult_q  <= 1'b0;
            exc_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            mult_q  <= mult_d;
            exc_q   <= exc_d;
            tmo_q   <= tmo_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign stall          = (state_q != S_IDLE);
    assign md_operandA    = a_q;
    assign md_operandB    = b_q;
    assign md_ctrl_mult   = (state_q == S_START) &&  mult_q;
    assign md_ctrl_div    = (state_q == S_START) && !mult_q;
    assign resp_valid     = (state_q == S_DONE);
    assign resp_result    = res_q;
    assign resp_tag       = tag_q;
    assign resp_exception = exc_q;
    assign resp_timeout   = tmo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: a behavioural multdiv stand-in, a request driver
// that pushes expected responses, and an independent response monitor.
module tb_multdiv_sequencer;

    localparam int W   = 32;
    localparam int TW  = 5;
    localparam int TMO = 64;

    logic          clock;
    logic          reset;
    logic          req_valid, req_ready, req_mult, req_div;
    logic [W-1:0]  req_a, req_b;
    logic [TW-1:0] req_tag;
    logic          flush, stall;
    logic [W-1:0]  md_operandA, md_operandB, md_result;
    logic          md_ctrl_mult, md_ctrl_div, md_exception, md_ready;
    logic          resp_valid;
    wire           resp_ready;
    logic [W-1:0]  resp_result;
    logic [TW-1:0] resp_tag;
    logic          resp_exception, resp_timeout;

    multdiv_sequencer #(.WIDTH(W), .TAG_W(TW), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mult(req_mult), .req_div(req_div),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush), .stall(stall),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_tag(resp_tag), .resp_exception(resp_exception), .resp_timeout(resp_timeout)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Signed multiply / divide as the multdiv unit defines them; exception when the
    // true value does not fit in W bits, or on divide by zero (result 0).
    function automatic void ref_md(input bit mult, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output bit e);
        longint sa, sb_, v;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (!mult && b == '0) begin
            r = '0;
            e = 1'b1;
        end else begin
            v = mult ? sa * sb_ : sa / sb_;
            r = v[W-1:0];
            e = (v != longint'($signed(r)));
        end
    endfunction

    typedef struct {
        logic [W-1:0]  result;
        logic [TW-1:0] tag;
        bit            exc;
        bit            tmo;
        int            cyc;
    } resp_t;

    resp_t sb[$];
    resp_t cur;
    bit    holding = 0;

    // ---------------- multdiv unit stand-in ----------------
    int           md_delay = 10;
    bit           md_stale = 0;
    int           md_cd = -1;
    logic [W-1:0] md_r_pend, cap_a, cap_b;
    bit           md_e_pend;
    int           exp_pulse_cyc = -1;
    bit           exp_pulse_mult = 0;
    int           pulse_cnt = 0;
    int           exp_pulses = 0;
    bit           prev_pulse = 0;

    initial begin
        md_ready = 1'b0;
        md_result = '0;
        md_exception = 1'b0;
        forever begin
            @(negedge clock); #1;
            md_ready = 1'b0;
            md_result = '0;
            md_exception = 1'b0;
            if (reset && (md_ctrl_mult || md_ctrl_div)) begin
                pulse_cnt++;
                check("pulse_onehot", md_ctrl_mult & md_ctrl_div, 0);
                check("pulse_gap", prev_pulse, 0);
                check("pulse_cycle", cyc, exp_pulse_cyc);
                check("pulse_kind", md_ctrl_mult, exp_pulse_mult);
                cap_a = md_operandA;
                cap_b = md_operandB;
                ref_md(md_ctrl_mult, cap_a, cap_b, md_r_pend, md_e_pend);
                md_cd = (md_delay > 0) ? md_delay : -1;
                if (md_stale) begin
                    md_ready = 1'b1;
                    md_result = 32'hDEAD_BEEF;
                    md_exception = 1'b1;
                end
                prev_pulse = 1'b1;
            end else begin
                prev_pulse = 1'b0;
                if (md_cd > 0) begin
                    if (reset && stall) begin
                        check("operand_a_stable", md_operandA, cap_a);
                        check("operand_b_stable", md_operandB, cap_b);
                    end
                    md_cd--;
                    if (md_cd == 0) begin
                        md_ready = 1'b1;
                        md_result = md_r_pend;
                        md_exception = md_e_pend;
                        md_cd = -1;
                    end
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    logic rr_rand = 1'b0;
    bit   hold_off = 0;
    bit   force_ready = 0;
    assign resp_ready = force_ready | (rr_rand & ~hold_off);

    initial begin
        forever begin
            @(negedge clock); #1;
            rr_rand = 1'($urandom_range(0, 1));
            #2;
            if (!reset) begin
                holding = 0;
            end else if (resp_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", resp_valid, 0);
                    end else begin
                        cur = sb.pop_front();
                        holding = 1;
                        check("resp_latency", cyc, cur.cyc);
                        check("resp_result", resp_result, cur.result);
                        check("resp_tag", resp_tag, cur.tag);
                        check("resp_exception", resp_exception, cur.exc);
                        check("resp_timeout", resp_timeout, cur.tmo);
                    end
                end else begin
                    check("hold_result", resp_result, cur.result);
                    check("hold_tag", resp_tag, cur.tag);
                    check("hold_flags", {resp_exception, resp_timeout}, {cur.exc, cur.tmo});
                end
                if (flush || resp_ready) holding = 0;
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic tick();
        @(negedge clock); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        while (!(req_ready && md_cd <= 0 && !holding)) begin
            tick();
            n++;
            if (n > 400) begin
                n_cmp++;
                n_err++;
                $display("FAIL idle_wait: sequencer still busy after %0d cycles", n);
                return;
            end
        end
    endtask

    task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input int delay, input bit stale,
                         input bit expect_resp);
        resp_t e;
        int    c0;
        wait_idle();
        md_delay = delay;
        md_stale = stale;
        req_valid = 1'b1;
        req_mult = m;
        req_div = d;
        req_a = a;
        req_b = b;
        req_tag = tag;
        c0 = cyc;
        e.tag = tag;
        if (m ^ d) begin
            exp_pulse_cyc = c0 + 1;
            exp_pulse_mult = m;
            exp_pulses++;
            if (delay >= 1 && delay <= TMO) begin
                ref_md(m, a, b, e.result, e.exc);
                e.tmo = 1'b0;
                e.cyc = c0 + 2 + delay;
            end else begin
                e.result = '0;
                e.exc = 1'b1;
                e.tmo = 1'b1;
                e.cyc = c0 + TMO + 2;
            end
        end else begin
            exp_pulse_cyc = -1;
            e.result = '0;
            e.exc = 1'b1;
            e.tmo = 1'b0;
            e.cyc = c0 + 1;
        end
        if (expect_resp) sb.push_back(e);
        tick();
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_mult = 1'($urandom_range(0, 1));
        req_div = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    int  p;
    int  kind;
    int  dly;
    bit  rm, rd;

    initial begin
        reset = 1'b0;
        req_valid = 1'b0;
        req_mult = 1'b0;
        req_div = 1'b0;
        req_a = '0;
        req_b = '0;
        req_tag = '0;
        flush = 1'b0;
        #3;
        check("reset_req_ready", req_ready, 1);
        check("reset_outputs", {stall, md_ctrl_mult, md_ctrl_div, resp_valid, resp_exception, resp_timeout}, 0);
        check("reset_data", {md_operandA, md_operandB}, 0);
        tick();
        reset = 1'b1;

        // Multiply overflow: -1 * -2^31
        issue(1, 0, 32'hFFFF_FFFF, 32'h8000_0000, 5'd3, 33, 0, 1);
        // Divide, then divide by zero
        issue(0, 1, 32'd100, 32'd7, 5'd12, 20, 1, 1);
        issue(0, 1, 32'd100, 32'd0, 5'd12, 18, 0, 1);
        // Timeout, ready on the very last WAIT cycle, ready one cycle too late
        issue(1, 0, 32'd9, 32'd9, 5'd21, -1, 0, 1);
        issue(0, 1, 32'd81, 32'd9, 5'd22, TMO, 0, 1);
        issue(1, 0, 32'd5, 32'd5, 5'd23, TMO + 1, 0, 1);

        // Flush during WAIT: drained silently, then a normal request
        issue(1, 0, 32'd11, 32'd13, 5'd7, 20, 0, 0);
        p = cyc;
        while (cyc < p + 5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (cyc < p + 20) begin
            check("abort_stall", stall, 1);
            check("abort_req_ready", req_ready, 0);
            tick();
        end
        check("abort_end_stall", stall, 1);
        tick();
        check("abort_idle_stall", stall, 0);
        check("abort_idle_ready", req_ready, 1);
        issue(1, 0, 32'd6, 32'd7, 5'd9, 12, 0, 1);

        // Illegal op held without resp_ready for 10 cycles
        issue(1, 1, 32'hAAAA_5555, 32'h1234_5678, 5'd17, 5, 0, 1);
        hold_off = 1;
        repeat (10) begin
            check("illegal_hold_valid", resp_valid, 1);
            tick();
        end
        hold_off = 0;

        // Flush in DONE together with resp_ready drops the response
        issue(0, 0, 32'd1, 32'd2, 5'd30, 5, 0, 1);
        hold_off = 1;
        tick();
        force_ready = 1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        force_ready = 0;
        hold_off = 0;
        check("flush_done_valid", resp_valid, 0);
        check("flush_done_ready", req_ready, 1);

        // Asynchronous reset in WAIT; the stale md_ready must not produce a response
        issue(0, 1, 32'd500, 32'd5, 5'd4, 30, 0, 1);
        repeat (8) tick();
        #4;
        reset = 1'b0;
        #1;
        check("areset_req_ready", req_ready, 1);
        check("areset_outputs", {stall, md_ctrl_mult, md_ctrl_div, resp_valid, resp_exception, resp_timeout}, 0);
        check("areset_data", {md_operandA, md_operandB, resp_result, resp_tag}, 0);
        sb.delete();
        exp_pulse_cyc = -1;
        tick();
        tick();
        reset = 1'b1;
        repeat (30) tick();
        check("post_reset_stall", stall, 0);
        check("post_reset_valid", resp_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 19);
            rm = 1'($urandom_range(0, 1));
            rd = !rm;
            if (kind == 0) begin
                rm = 1; rd = 1;
            end else if (kind == 1) begin
                rm = 0; rd = 0;
            end
            dly = $urandom_range(1, 40);
            if (kind == 2) dly = -1;
            if (kind == 3) dly = TMO;
            issue(rm, rd, rand_operand(), rand_operand(), 5'($urandom), dly,
                  $urandom_range(0, 3) == 0, 1);
        end

        wait_idle();
        repeat (3) tick();
        check("pulse_count", pulse_cnt, exp_pulses);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
